gpio_arbiter: RTL and testbench
===============================

GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, GPIO register width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester request; bit i for requester i.
REQ-005 op0, op1  input  2 each  operation: 0 write, 1 set-bits, 2 clear-bits, 3 toggle-bits.
REQ-006 sel0, sel1  input  2 each  target register: 0 odr, 1 ddr, 2 pr, 3 invalid.
REQ-007 data0, data1  input  WIDTH each  operand.
REQ-008 odr_cur, ddr_cur, pr_cur  input  WIDTH each  current GPIO register contents.
REQ-009 odr_in, ddr_in, pr_in  output  WIDTH each  new register value to GPIO.
REQ-010 odr_write, ddr_write, pr_write  output  1 each  GPIO register write strobes.
REQ-011 ack  output  2  one-cycle completion pulse per requester.
REQ-012 err  output  1  one-cycle pulse, coincident with ack, for an invalid sel.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, WRITE, ACK.
REQ-015 IDLE: on an edge with any req bit high, latch winner index, op, sel and data, then go to WRITE; otherwise stay in IDLE.
REQ-016 Arbitration is round-robin: with both req bits high, grant the requester not granted last; with one bit high, grant that one.
REQ-017 WRITE: for exactly one cycle, assert only the strobe selected by the latched sel; then go to ACK.
REQ-018 New value from latched op and the selected *_cur: write = data; set = cur OR data; clear = cur AND NOT data; toggle = cur XOR data.
REQ-019 In WRITE, all three *_in outputs carry the computed value; outside WRITE they carry zero.
REQ-020 Invalid sel (3): no strobe in WRITE; err pulses with ack in ACK.
REQ-021 ACK: ack[winner] high for exactly one cycle; then go to IDLE.
REQ-022 Latency: req sampled at edge N -> strobe in cycle N+1 -> ack in cycle N+2; earliest next grant at edge N+3.
REQ-023 Requesters hold op/sel/data stable from asserting req until ack; a requester keeping req high after ack is treated as a new request.
REQ-024 req dropped after latching does not abort the operation; it still completes with ack.
REQ-025 At most one strobe is high in any cycle; strobes never assert outside WRITE.

Reset
REQ-026 While reset is high, asynchronously: state = IDLE; ack, err, busy and all strobes = 0; *_in = 0.
REQ-027 Reset clears the round-robin pointer so requester 0 wins the first contested grant.
REQ-028 Reset asserted in WRITE removes the strobe immediately; the in-flight operation is discarded with no ack.

Configuration
REQ-029 Macro GPIO_ARB_LOCK_EN adds input lock (2 bits, one per requester).
REQ-030 With GPIO_ARB_LOCK_EN defined: if lock[winner] is high in ACK and req[winner] is high, the next grant goes to the same requester regardless of the other request.
REQ-031 With GPIO_ARB_LOCK_EN defined: the lock is released when lock[winner] is low in ACK or req[winner] is low in IDLE.
REQ-032 Without GPIO_ARB_LOCK_EN: no lock port exists and strict round-robin applies.

Verification
REQ-033 Single write: reset, req=01, op0=0, sel0=0, data0=8'hA5 -> odr_write high one cycle with odr_in=8'hA5, then ack=01 one cycle later.
REQ-034 Read-modify-write: ddr_cur=8'hF0; req1 set with data 8'h0F -> ddr_in=8'hFF; clear with data 8'h30 -> 8'hC0; toggle with data 8'hFF -> 8'h0F.
REQ-035 Contention: req=11 held continuously from reset -> ack order 01, 10, 01, 10; each grant 3 cycles apart.
REQ-036 Invalid target: sel0=3 -> no strobe; err and ack[0] high together; odr/ddr/pr values unchanged.
REQ-037 Async reset mid-op: assert reset during WRITE -> strobe drops in the same cycle; no ack; after release, busy=0.
REQ-038 Lock (GPIO_ARB_LOCK_EN defined): req=11, lock0=1 -> requester 0 granted three times consecutively; lock0=0 -> next grant goes to requester 1.

Source files
------------

// File: rtl/gpio_arbiter.sv
// Two-requester round-robin arbiter doing write/set/clear/toggle on GPIO odr/ddr/pr registers.
// Optional `define GPIO_ARB_LOCK_EN adds a per-requester lock input that holds the grant.
module gpio_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [1:0]       sel0,
  input  logic [1:0]       sel1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] odr_cur,
  input  logic [WIDTH-1:0] ddr_cur,
  input  logic [WIDTH-1:0] pr_cur,
`ifdef GPIO_ARB_LOCK_EN
  input  logic [1:0]       lock,
`endif
  output logic [WIDTH-1:0] odr_in,
  output logic [WIDTH-1:0] ddr_in,
  output logic [WIDTH-1:0] pr_in,
  output logic             odr_write,
  output logic             ddr_write,
  output logic             pr_write,
  output logic [1:0]       ack,
  output logic             err,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             winner_q, winner_d;
  logic             prio_q, prio_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             grant_idx;
  logic [WIDTH-1:0] cur_sel;
  logic [WIDTH-1:0] new_val;

`ifdef GPIO_ARB_LOCK_EN
  logic lock_q, lock_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  // Lock is re-evaluated on every ACK; a dropped request in IDLE also frees it.
  always_comb begin
    lock_d = lock_q;
    if (state_q == ACK)
      lock_d = lock[winner_q] & req[winner_q];
    else if (state_q == IDLE && lock_q && !req[winner_q])
      lock_d = 1'b0;
  end
`endif

  always_comb begin
    if (req == 2'b11) grant_idx = prio_q;
    else              grant_idx = req[1];
`ifdef GPIO_ARB_LOCK_EN
    if (lock_q && req[winner_q]) grant_idx = winner_q;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      prio_q   <= 1'b0;
      op_q     <= 2'd0;
      sel_q    <= 2'd0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      prio_q   <= prio_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    prio_d   = prio_q;
    op_d     = op_q;
    sel_d    = sel_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = WRITE;
          winner_d = grant_idx;
          prio_d   = ~grant_idx;
          op_d     = grant_idx ? op1   : op0;
          sel_d    = grant_idx ? sel1  : sel0;
          data_d   = grant_idx ? data1 : data0;
        end
      end
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    cur_sel = odr_cur;
      2'd1:    cur_sel = ddr_cur;
      2'd2:    cur_sel = pr_cur;
      default: cur_sel = '0;
    endcase
    case (op_q)
      2'd0:    new_val = data_q;
      2'd1:    new_val = cur_sel | data_q;
      2'd2:    new_val = cur_sel & ~data_q;
      default: new_val = cur_sel ^ data_q;
    endcase
  end

  // Output logic
  always_comb begin
    odr_write   = (state_q == WRITE) && (sel_q == 2'd0);
    ddr_write   = (state_q == WRITE) && (sel_q == 2'd1);
    pr_write    = (state_q == WRITE) && (sel_q == 2'd2);
    odr_in      = (state_q == WRITE) ? new_val : '0;
    ddr_in      = (state_q == WRITE) ? new_val : '0;
    pr_in       = (state_q == WRITE) ? new_val : '0;
    ack         = (state_q == ACK) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    err         = (state_q == ACK) && (sel_q == 2'd3);
    busy        = (state_q != IDLE);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: stimulus pushes expected strobe/ack events, a negedge monitor pops and compares.
module tb_gpio_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'd0, op1 = 2'd0, sel0 = 2'd0, sel1 = 2'd0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic [7:0] odr_cur = 8'h00, ddr_cur = 8'hF0, pr_cur = 8'h3C;
`ifdef GPIO_ARB_LOCK_EN
  logic [1:0] lock = 2'b00;
`endif
  logic [7:0] odr_in, ddr_in, pr_in;
  logic       odr_write, ddr_write, pr_write;
  logic [1:0] ack;
  logic       err, busy;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int last_ack_cyc = 0;
  int ack_times[$];
  logic [12:0] exp_q[$];

  gpio_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op0(op0), .op1(op1), .sel0(sel0), .sel1(sel1),
    .data0(data0), .data1(data1),
    .odr_cur(odr_cur), .ddr_cur(ddr_cur), .pr_cur(pr_cur),
`ifdef GPIO_ARB_LOCK_EN
    .lock(lock),
`endif
    .odr_in(odr_in), .ddr_in(ddr_in), .pr_in(pr_in),
    .odr_write(odr_write), .ddr_write(ddr_write), .pr_write(pr_write),
    .ack(ack), .err(err), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2:0]  strobes;
    logic [12:0] e;
    if (!reset) begin
      strobes = {pr_write, ddr_write, odr_write};
      if (strobes != 3'b000) begin
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {19'd0, 2'b01, strobes, odr_in}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_event", {19'd0, 2'b01, strobes, odr_in}, {19'd0, e});
          check("ddr_in_value", {24'd0, ddr_in}, {24'd0, e[7:0]});
          check("pr_in_value", {24'd0, pr_in}, {24'd0, e[7:0]});
        end
      end
      if (ack != 2'b00) begin
        last_ack_cyc = cyc;
        ack_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {19'd0, 2'b10, err, ack, 8'h00}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_event", {19'd0, 2'b10, err, ack, 8'h00}, {19'd0, e});
          check("in_zero_in_ack", {8'd0, odr_in, ddr_in, pr_in}, 32'd0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack_err", {29'd0, ack, err}, 32'd0);
    check("rst_strobes", {29'd0, pr_write, ddr_write, odr_write}, 32'd0);
    check("rst_in", {8'd0, odr_in, ddr_in, pr_in}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_op(input int r, input logic [1:0] op, input logic [1:0] sel,
                       input logic [7:0] d, input logic [7:0] exp_v);
    logic [2:0] oh;
    @(negedge clk);
    if (r == 0) begin op0 = op; sel0 = sel; data0 = d; end
    else        begin op1 = op; sel1 = sel; data1 = d; end
    oh = 3'b001 << sel;
    if (sel != 2'd3) exp_q.push_back({2'b01, oh, exp_v});
    exp_q.push_back({2'b10, (sel == 2'd3), (r == 0) ? 2'b01 : 2'b10, 8'h00});
    req = (r == 0) ? 2'b01 : 2'b10;
    @(posedge clk);
    #1 req = 2'b00;
    wait_idle();
  endtask

  initial begin
    apply_reset();

    // single write with latency check
    do_op(0, 2'd0, 2'd0, 8'hA5, 8'hA5);
    check("strobe_to_ack", last_ack_cyc - last_strobe_cyc, 32'd1);

    // read-modify-write on ddr (ddr_cur = F0)
    do_op(1, 2'd1, 2'd1, 8'h0F, 8'hFF);
    do_op(1, 2'd2, 2'd1, 8'h30, 8'hC0);
    do_op(1, 2'd3, 2'd1, 8'hFF, 8'h0F);
    do_op(0, 2'd3, 2'd2, 8'hFF, 8'hC3);
    do_op(0, 2'd1, 2'd0, 8'h81, 8'h81);

    // invalid target: no strobe, err with ack
    do_op(0, 2'd1, 2'd3, 8'hFF, 8'h00);

    // contention from reset
    apply_reset();
    ack_times.delete();
    op0 = 2'd0; sel0 = 2'd0; data0 = 8'h11;
    op1 = 2'd0; sel1 = 2'd1; data1 = 8'h22;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({2'b01, 3'b001, 8'h11});
      exp_q.push_back({2'b10, 1'b0, 2'b01, 8'h00});
      exp_q.push_back({2'b01, 3'b010, 8'h22});
      exp_q.push_back({2'b10, 1'b0, 2'b10, 8'h00});
    end
    @(negedge clk);
    req = 2'b11;
    repeat (10) @(posedge clk);
    #1 req = 2'b00;
    wait_idle();
    check("contention_acks", ack_times.size(), 32'd4);
    for (int i = 1; i < ack_times.size(); i++)
      check("grant_spacing", ack_times[i] - ack_times[i-1], 32'd3);

    // async reset during WRITE
    @(negedge clk);
    op0 = 2'd0; sel0 = 2'd1; data0 = 8'h5A;
    req = 2'b01;
    @(posedge clk);
    #2;
    check("midop_strobe_before", {31'd0, ddr_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("midop_strobe_dropped", {31'd0, ddr_write}, 32'd0);
    check("midop_in_zero", {24'd0, ddr_in}, 32'd0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_busy_after", {31'd0, busy}, 32'd0);

`ifdef GPIO_ARB_LOCK_EN
    apply_reset();
    op0 = 2'd0; sel0 = 2'd0; data0 = 8'h11;
    op1 = 2'd0; sel1 = 2'd1; data1 = 8'h22;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b01, 3'b001, 8'h11});
      exp_q.push_back({2'b10, 1'b0, 2'b01, 8'h00});
    end
    exp_q.push_back({2'b01, 3'b010, 8'h22});
    exp_q.push_back({2'b10, 1'b0, 2'b10, 8'h00});
    @(negedge clk);
    req = 2'b11;
    lock = 2'b01;
    repeat (7) @(posedge clk);
    #1 lock = 2'b00;
    repeat (3) @(posedge clk);
    #1 req = 2'b00;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
